// File: rtl/noc_sched_pkg.sv
// Shared scheduler definitions: FSM encoding, PE-id width helper and NoC packet field offsets.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package noc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Packet layout, LSB first: dest_x, dest_y, payload.
    localparam int DEST_X_LSB = 0;

    function automatic int dest_y_lsb(input int xs);
        return xs;
    endfunction

    function automatic int payload_lsb(input int xs, input int ys);
        return xs + ys;
    endfunction

    function automatic int pe_id_width(input int num_pe);
        return (num_pe > 2) ? $clog2(num_pe) : 1;
    endfunction

endpackage

// File: rtl/pe_credit_tracker.sv
// Per-PE outstanding-word counters with credit-return underflow detection.
// Latency: counts update one cycle after dispatch/return; credit_ok, all_zero and underflow are combinational.
// Backpressure: none here; credit_ok gates the scheduler's ingress ready.
module pe_credit_tracker #(
    parameter int NUM_PE     = 16,
    parameter int ID_W       = 4,
    parameter int MAX_CREDIT = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispatch_vld,
    input  logic [ID_W-1:0]   dispatch_id,
    input  logic              ret_vld,
    input  logic [ID_W-1:0]   ret_id,
    input  logic              ret_id_ok,
    output logic [NUM_PE-1:0] credit_ok,
    output logic              all_zero,
    output logic              underflow
);

    logic [CNT_W-1:0]  cnt [NUM_PE];
    logic [NUM_PE-1:0] inc;
    logic [NUM_PE-1:0] dec;
    logic              ret_cnt_zero;

    // Out-of-mesh coordinates fall through with ret_cnt_zero left at 1.
    always_comb begin
        ret_cnt_zero = 1'b1;
        for (int i = 0; i < NUM_PE; i++) begin
            if (ret_id == ID_W'(i)) ret_cnt_zero = (cnt[i] == '0);
        end
    end

    assign underflow = ret_vld && (!ret_id_ok || (ret_id == '0) || ret_cnt_zero);

    always_comb begin
        inc       = '0;
        dec       = '0;
        credit_ok = '0;
        all_zero  = 1'b1;
        for (int i = 0; i < NUM_PE; i++) begin
            inc[i]       = dispatch_vld && (dispatch_id == ID_W'(i));
            dec[i]       = ret_vld && !underflow && (ret_id == ID_W'(i));
            credit_ok[i] = (i != 0) && (cnt[i] < CNT_W'(MAX_CREDIT));
            if (cnt[i] != '0) all_zero = 1'b0;
        end
    end

    // A dispatch and a return to the same PE in one cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PE; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (inc[i] && !dec[i])      cnt[i] <= cnt[i] + CNT_W'(1);
                else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pci_pe_scheduler.sv
// Round-robin PCIe-to-NoC word scheduler over mesh PEs 1..X*Y-1 with per-PE credits; SCHED_SKIP_EN skips full PEs.
// Latency: accepted word appears on o_data_noc the next cycle.
// Backpressure: o_ready_pci low outside RUN, while the output stage is stalled, or when the target lacks credit.
module pci_pe_scheduler
    import noc_sched_pkg::*;
#(
    parameter int X          = 4,
    parameter int Y          = 4,
    parameter int data_width = 256,
    parameter int x_size     = 2,
    parameter int y_size     = 2,
    parameter int MAX_CREDIT = 4,
    parameter int IMAGE_SIZE = 262144
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_start,
    input  logic                                i_valid_pci,
    input  logic [data_width-1:0]               i_data_pci,
    output logic                                o_ready_pci,
    output logic                                o_valid_noc,
    output logic [x_size+y_size+data_width-1:0] o_data_noc,
    input  logic                                i_ready_noc,
    input  logic                                i_ret_valid,
    input  logic [x_size-1:0]                   i_ret_x,
    input  logic [y_size-1:0]                   i_ret_y,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_err
);

    localparam int NUM_PE = X * Y;
    localparam int ID_W   = pe_id_width(NUM_PE);
    localparam int CNT_W  = $clog2(MAX_CREDIT + 1);
    localparam int ACC_W  = $clog2(IMAGE_SIZE + 1);
    localparam int PKT_W  = x_size + y_size + data_width;
    localparam int Y_LSB  = dest_y_lsb(x_size);
    localparam int P_LSB  = payload_lsb(x_size, y_size);

    sched_state_t      state;
    logic [ID_W-1:0]   target;
    logic [ACC_W-1:0]  acc_cnt;
    logic [ACC_W-1:0]  acc_cnt_nxt;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W-1:0]   next_ptr;
    logic              sel_ok;
    logic [x_size-1:0] sel_x;
    logic [y_size-1:0] sel_y;
    logic [ID_W-1:0]   ret_id;
    logic              ret_id_ok;
    logic [NUM_PE-1:0] credit_ok;
    logic              all_zero;
    logic              underflow;
    logic              acc;
    logic [PKT_W-1:0]  pkt;

    always_comb begin
        ret_id    = '0;
        ret_id_ok = 1'b0;
        for (int yy = 0; yy < Y; yy++) begin
            for (int xx = 0; xx < X; xx++) begin
                if ((i_ret_x == x_size'(xx)) && (i_ret_y == y_size'(yy))) begin
                    ret_id    = ID_W'(yy * X + xx);
                    ret_id_ok = 1'b1;
                end
            end
        end
    end

`ifdef SCHED_SKIP_EN
    logic [ID_W-1:0] cand_id;
    int              cand;

    // Scan downward so the candidate closest to the pointer wins.
    always_comb begin
        sel_id  = target;
        sel_ok  = 1'b0;
        cand    = 0;
        cand_id = '0;
        for (int k = NUM_PE - 2; k >= 0; k--) begin
            cand = int'(target) + k;
            if (cand >= NUM_PE) cand = cand - (NUM_PE - 1);
            cand_id = ID_W'(cand);
            if (credit_ok[cand_id]) begin
                sel_id = cand_id;
                sel_ok = 1'b1;
            end
        end
    end
`else
    assign sel_id = target;
    assign sel_ok = credit_ok[target];
`endif

    assign next_ptr = (sel_id == ID_W'(NUM_PE - 1)) ? ID_W'(1) : sel_id + ID_W'(1);

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int yy = 0; yy < Y; yy++) begin
            for (int xx = 0; xx < X; xx++) begin
                if (sel_id == ID_W'(yy * X + xx)) begin
                    sel_x = x_size'(xx);
                    sel_y = y_size'(yy);
                end
            end
        end
    end

    always_comb begin
        pkt                            = '0;
        pkt[DEST_X_LSB +: x_size]      = sel_x;
        pkt[Y_LSB +: y_size]           = sel_y;
        pkt[P_LSB +: data_width]       = i_data_pci;
    end

    assign o_ready_pci = (state == ST_RUN) && (!o_valid_noc || i_ready_noc) && sel_ok;
    assign acc         = i_valid_pci && o_ready_pci;
    assign acc_cnt_nxt = acc_cnt + ACC_W'(acc);

    pe_credit_tracker #(
        .NUM_PE     (NUM_PE),
        .ID_W       (ID_W),
        .MAX_CREDIT (MAX_CREDIT),
        .CNT_W      (CNT_W)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .dispatch_vld (acc),
        .dispatch_id  (sel_id),
        .ret_vld      (i_ret_valid),
        .ret_id       (ret_id),
        .ret_id_ok    (ret_id_ok),
        .credit_ok    (credit_ok),
        .all_zero     (all_zero),
        .underflow    (underflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_noc <= 1'b0;
            o_data_noc  <= '0;
        end else if (acc) begin
            o_valid_noc <= 1'b1;
            o_data_noc  <= pkt;
        end else if (i_ready_noc) begin
            o_valid_noc <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            target  <= ID_W'(1);
            acc_cnt <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state   <= ST_RUN;
                        target  <= ID_W'(1);
                        acc_cnt <= '0;
                        o_busy  <= 1'b1;
                        o_done  <= 1'b0;
                        o_err   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (acc) begin
                        target  <= next_ptr;
                        acc_cnt <= acc_cnt_nxt;
                        if (acc_cnt_nxt == ACC_W'(IMAGE_SIZE)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (all_zero && !o_valid_noc) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A bad return in the same cycle as a restart still flags.
            if (underflow) o_err <= 1'b1;
        end
    end

endmodule

// File: doc/pci_pe_scheduler.md
PCI_PE_SCHEDULER -- requirements
Module: pci_pe_scheduler

Interface
REQ-001 SHALL have parameter X, default 4: mesh columns.
REQ-002 SHALL have parameter Y, default 4: mesh rows.
REQ-003 SHALL have parameter data_width, default 256: payload bits.
REQ-004 SHALL have parameter x_size, default 2: x-coordinate bits.
REQ-005 SHALL have parameter y_size, default 2: y-coordinate bits.
REQ-006 SHALL have parameter MAX_CREDIT, default 4: outstanding words per PE.
REQ-007 SHALL have parameter IMAGE_SIZE, default 262144: words per job.
REQ-008 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-009 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port i_start, input, 1, job start pulse.
REQ-011 SHALL have ports i_valid_pci (input, 1), i_data_pci (input, data_width) and o_ready_pci (output, 1): PCIe ingress handshake.
REQ-012 SHALL have ports o_valid_noc (output, 1), o_data_noc (output, x_size+y_size+data_width) and i_ready_noc (input, 1): NoC injection handshake.
REQ-013 SHALL have ports i_ret_valid (input, 1), i_ret_x (input, x_size) and i_ret_y (input, y_size): credit return from a PE.
REQ-014 SHALL have outputs o_busy (1), o_done (1) and o_err (1).

Function
REQ-015 SHALL map PE id = y*X + x; workers are ids 1..X*Y-1, and id 0 (PCIe node) never receives a word.
REQ-016 SHALL format o_data_noc as {payload, dest_y, dest_x}, with dest_x in the LSBs.
REQ-017 SHALL implement FSM IDLE->RUN (i_start), RUN->DRAIN (accepted count == IMAGE_SIZE), DRAIN->DONE (all outstanding counts 0 and o_valid_noc==0), DONE->RUN (i_start).
REQ-018 SHALL ignore i_start outside IDLE and DONE.
REQ-019 SHALL drive o_ready_pci = (state==RUN) & (!o_valid_noc | i_ready_noc) & outstanding[target] < MAX_CREDIT.
REQ-020 SHALL, on i_valid_pci & o_ready_pci, register the packet into the output stage the same cycle (1-cycle latency), increment outstanding[target] and the accepted count, and advance target round-robin (wraps from X*Y-1 to 1).
REQ-021 SHALL hold o_valid_noc and o_data_noc stable until i_ready_noc is high.
REQ-022 SHALL, without SCHED_SKIP_EN, stall on a target with full credit and never skip it.
REQ-023 SHALL decrement outstanding[ret id] on i_ret_valid.
REQ-024 SHALL leave the count unchanged on a simultaneous dispatch and return to the same PE.
REQ-025 SHALL, on a return to a PE with outstanding==0 or to id 0, ignore the return and set o_err (sticky until rst or i_start).
REQ-026 SHALL set o_busy = RUN|DRAIN.
REQ-027 SHALL hold o_done high in DONE.
REQ-028 SHALL, on i_start from DONE, clear the accepted count and o_err and reset target to 1.

Reset
REQ-029 SHALL, on rst asserted at any time including mid-job, immediately force state IDLE, target 1, all outstanding counts 0, accepted count 0, o_valid_noc 0, o_data_noc 0, o_ready_pci 0, o_busy 0, o_done 0 and o_err 0.

Configuration
REQ-030 SHALL, when macro SCHED_SKIP_EN is defined, select as target the first id at or after the pointer (circular over 1..X*Y-1) with outstanding < MAX_CREDIT, then set the pointer to chosen+1.
REQ-031 SHALL, when SCHED_SKIP_EN is defined and no PE has credit, deassert o_ready_pci.
REQ-032 SHALL, when SCHED_SKIP_EN is undefined, behave strictly per REQ-022.

Structure
REQ-033 SHALL place the FSM state encoding, the PE-id width function and the packet field offsets in shared package noc_sched_pkg.
REQ-034 SHALL implement the per-PE outstanding counters and the underflow detection in sub-module pe_credit_tracker.

Verification (X=Y=2, data_width=8, MAX_CREDIT=2, IMAGE_SIZE=8)
REQ-035 SHALL check: rst pulse mid-RUN after 3 words -> all outputs 0, state IDLE, next job starts at PE1.
REQ-036 SHALL check: i_start, bytes 0x10..0x17 with immediate returns -> packets to (x,y) (1,0),(0,1),(1,1),(1,0),(0,1),(1,1),(1,0),(0,1), then o_done=1.
REQ-037 SHALL check: no returns -> o_ready_pci drops after 6 words; a PE1 return -> 7th word sent to (1,0).
REQ-038 SHALL check: i_ready_noc low 5 cycles -> o_data_noc stable and o_ready_pci 0 throughout.
REQ-039 SHALL check: return to (1,1) with outstanding 0 -> o_err=1, counts unchanged.
REQ-040 SHALL check: with SCHED_SKIP_EN, PE2 full and PE1/PE3 free with pointer at 2 -> next word goes to (1,1).
